uart_rx_fifo: RTL



---
 rtl/uart_rx_fifo.sv | 132 +++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : UART receive buffer: one-shot ack of receiver bytes into a
//            circular FWFT FIFO. Optional macro UART_RX_FIFO_DROP_EN drops
//            bytes that arrive while full and raises a sticky overrun flag.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int WIDTH_DATA = 8,
  parameter int DEPTH_LOG  = 4
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_rdy,
  input  logic [WIDTH_DATA-1:0] i_data,
  output logic                  o_re,
  output logic [WIDTH_DATA-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_pop,
  output logic [DEPTH_LOG:0]    o_count,
  output logic                  o_full,
  output logic                  o_ovf,
  input  logic                  i_ovf_clr
);

  localparam int                c_entries = 2 ** DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] c_depth  = {1'b1, {DEPTH_LOG{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    r_re;
  logic [DEPTH_LOG-1:0]    r_wr_ptr;
  logic [DEPTH_LOG-1:0]    r_rd_ptr;
  logic [DEPTH_LOG:0]      r_count;
  logic [WIDTH_DATA-1:0]   r_mem [0:c_entries-1];

  logic w_full;
  logic w_accept;
  logic w_take;
  logic w_push;
  logic w_pop;

  assign w_full = (r_count == c_depth);

`ifdef UART_RX_FIFO_DROP_EN
  assign w_accept = 1'b1;
`else
  assign w_accept = ~w_full;
`endif

  // Acceptance is judged on the pre-edge full flag, so a same-cycle pop
  // never opens room for a push on that edge.
  assign w_take = (r_state == S_IDLE) && i_rdy && w_accept;
  assign w_push = w_take && ~w_full;
  assign w_pop  = i_pop && (r_count != '0);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_rdy && w_accept) w_state_next = S_ACK;
      S_ACK:   w_state_next = S_WAIT;
      S_WAIT:  if (!i_rdy) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state <= S_IDLE;
      r_re    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_re    <= (w_state_next == S_ACK);
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + DEPTH_LOG'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_LOG'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (DEPTH_LOG+1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_LOG+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; contents are only observed through o_valid.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

`ifdef UART_RX_FIFO_DROP_EN
  logic r_ovf;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_ovf <= 1'b0;
    end else if (w_take && w_full) begin
      r_ovf <= 1'b1;
    end else if (i_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign o_ovf = r_ovf;
`else
  logic w_unused_ovf_clr;
  assign w_unused_ovf_clr = i_ovf_clr;
  assign o_ovf = 1'b0;
`endif

  assign o_re    = r_re;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;
  assign o_full  = w_full;

endmodule
`default_nettype wire
